assertion_event_logger: RTL

//   Collects violation pulses from up to NUM_CHK hardware assertion checkers
//   (e.g. the toggle-circuit FSM checkers) and records each failing cycle as
//   an event {checker id, multi flag, timestamp} in a FIFO. Events are read out

---
 rtl/assertion_event_logger.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/assertion_event_logger.sv
// -----------------------------------------------------------------------------
// assertion_event_logger
//
// Purpose:
//   Gathers violation pulses from NUM_CHK hardware assertion checkers. Each
//   cycle in which at least one checker fails becomes one event
//   {checker id, multi flag, timestamp}, stored in a DEPTH-entry FIFO. A
//   debug/readout unit drains the events over a valid/ready port. Per-checker
//   sticky flags, an overflow flag and a saturating drop counter summarise
//   activity even when the FIFO has overflowed.
//
// Parameters:
//   NUM_CHK  number of checker fail inputs (2..32)
//   TS_W     timestamp counter width
//   DEPTH    FIFO depth in events (power of 2, >= 2)
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-low reset
//   enable       in   1 = logging and timestamp counting active
//   clear        in   synchronous clear of FIFO, stickies, counters
//   fail_i       in   per-checker violation pulses, sampled every clk
//   evt_valid    out  FIFO head holds an event
//   evt_ready    in   consumer accepts the head this cycle
//   evt_id       out  lowest-index failing checker of the head event
//   evt_multi    out  more than one checker failed in the head event's cycle
//   evt_ts       out  timestamp of the head event's cycle
//   occupancy    out  number of events held in the FIFO
//   sticky_fail  out  bit i set once fail_i[i] has been seen while enabled
//   overflow     out  sticky: at least one event was dropped
//   drop_cnt     out  number of dropped events, saturating at 255
// -----------------------------------------------------------------------------
module assertion_event_logger #(
    parameter int NUM_CHK = 4,
    parameter int TS_W    = 16,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [NUM_CHK-1:0]         fail_i,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_CHK)-1:0] evt_id,
    output logic                       evt_multi,
    output logic [TS_W-1:0]            evt_ts,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [NUM_CHK-1:0]         sticky_fail,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int ID_W  = $clog2(NUM_CHK);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    // Entry layout, MSB to LSB: {id, multi, ts}
    localparam int ENT_W = ID_W + 1 + TS_W;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [TS_W-1:0]    ts_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic [NUM_CHK-1:0] sticky_q;
    logic               overflow_q;
    logic [7:0]         drop_cnt_q;
    logic [ENT_W-1:0]   mem [DEPTH];

    // -------------------------------------------------------------------------
    // Event formation
    // -------------------------------------------------------------------------
    logic            any_fail;
    logic            evt_det;
    logic [ID_W-1:0] det_id;
    logic            det_multi;
    logic [ENT_W-1:0] det_entry;

    assign any_fail = |fail_i;

    // A same-cycle clear wins: the event is simply discarded, never counted.
    assign evt_det = enable & ~clear & any_fail;

    // Lowest set index: scan from the top so the last hit is the lowest bit.
    always_comb begin
        det_id = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (fail_i[i]) begin
                det_id = ID_W'(i);
            end
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign det_multi = |(fail_i & (fail_i - NUM_CHK'(1)));

    assign det_entry = {det_id, det_multi, ts_q};

    // -------------------------------------------------------------------------
    // FIFO control
    //
    // Readout handshake: evt_valid is high whenever the FIFO is non-empty and
    // the head fields are stable while it stays high; the head is consumed at
    // a clk edge where evt_valid and evt_ready are both 1. evt_valid does not
    // depend on evt_ready, and an event pushed into an empty FIFO is only
    // visible from the following cycle (no bypass).
    // -------------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == OCC_FULL);

    assign pop  = ~fifo_empty & evt_ready & ~clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = evt_det & (~fifo_full | pop);
    assign drop = evt_det & fifo_full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable below the
    // occupancy count, and the outputs are forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= det_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Timestamp, stickies and drop accounting
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else if (clear) begin
            ts_q <= '0;
        end else if (enable) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q <= '0;
        end else if (clear) begin
            sticky_q <= '0;
        end else if (enable) begin
            // Independent of FIFO state: a dropped event still marks its checker.
            sticky_q <= sticky_q | fail_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic [ENT_W-1:0] head;

    assign head = mem[rd_ptr_q];

    assign evt_valid   = ~fifo_empty;
    assign evt_id      = fifo_empty ? '0   : head[ENT_W-1 -: ID_W];
    assign evt_multi   = fifo_empty ? 1'b0 : head[TS_W];
    assign evt_ts      = fifo_empty ? '0   : head[TS_W-1:0];
    assign occupancy   = occ_q;
    assign sticky_fail = sticky_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
